// File: rtl/fpmul_arb_pkg.sv
// Shared definitions for the float-multiplier arbiter.
// Format is 27 bits: sign, 8-bit exponent (bias 127) and 18-bit fraction
// with a hidden leading one.
package fpmul_arb_pkg;

    localparam int FP_W      = 27;
    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 18;
    localparam int FP_BIAS   = 127;

    typedef struct packed {
        logic                 s;
        logic [FP_EXP_W-1:0]  e;
        logic [FP_FRAC_W-1:0] f;
    } fp27_t;

    localparam logic [FP_W-1:0] FP_ONE = 27'h1FC0000;

endpackage

// File: rtl/fpmul_core.sv
// Combinational 27-bit float multiplier.
// Ports:
//   a_i, b_i : operands
//   prod_o   : product
// Numeric rules: either exponent zero -> 0; exponent sum below 128 -> 0;
// fraction is truncated; exponent overflow wraps (no saturation).
module fpmul_core
    import fpmul_arb_pkg::*;
(
    input  logic [FP_W-1:0] a_i,
    input  logic [FP_W-1:0] b_i,
    output logic [FP_W-1:0] prod_o
);

    fp27_t a;
    fp27_t b;
    fp27_t p;
    logic [FP_FRAC_W:0]       ma;
    logic [FP_FRAC_W:0]       mb;
    logic [2*FP_FRAC_W+1:0]   mprod;
    logic [FP_EXP_W:0]        esum;
    logic [FP_EXP_W-1:0]      eres;
    logic                     unused_lsbs;

    always_comb begin
        a     = fp27_t'(a_i);
        b     = fp27_t'(b_i);
        ma    = {1'b1, a.f};
        mb    = {1'b1, b.f};
        mprod = {{(FP_FRAC_W+1){1'b0}}, ma} * {{(FP_FRAC_W+1){1'b0}}, mb};
        esum  = {1'b0, a.e} + {1'b0, b.e};
        // 8-bit wrap here is the intended "no saturation" behaviour
        eres  = a.e + b.e - FP_EXP_W'(FP_BIAS) + {{(FP_EXP_W-1){1'b0}}, mprod[2*FP_FRAC_W+1]};
        p     = '0;
        if (a.e != '0 && b.e != '0 && esum >= 9'd128) begin
            p.s = a.s ^ b.s;
            p.e = eres;
            p.f = mprod[2*FP_FRAC_W+1] ? mprod[2*FP_FRAC_W:FP_FRAC_W+1]
                                        : mprod[2*FP_FRAC_W-1:FP_FRAC_W];
        end
        prod_o = p;
    end

    assign unused_lsbs = ^mprod[FP_FRAC_W-1:0];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter owning the search pointer.
// Ports:
//   clk_i, rst_i : clock, async active-high reset
//   req_i        : request vector
//   advance_i    : the current grant is taken this cycle
//   gnt_o        : one-hot grant (combinational)
// The pointer moves to one past the granted index when advance_i is high.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] gnt_idx;
    logic             found;

    always_comb begin
        gnt_o   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        // first pass: pointer upward; second pass: wrap from index 0
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && k >= int'(ptr_q) && req_i[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
                gnt_idx  = PTR_W'(k);
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && k < int'(ptr_q) && req_i[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
                gnt_idx  = PTR_W'(k);
            end
        end
        ptr_d = ptr_q;
        if (advance_i && found) begin
            ptr_d = (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one float multiplier between NUM_REQ requesters.
// Ports:
//   iClk, iRst  : clock, async active-high reset
//   iReqValid   : per-requester operand valid
//   iReqA/iReqB : packed operands, requester k at [27k+26:27k]
//   oReqReady   : one-hot grant, pair accepted on valid&ready
//   oRespValid  : one-hot result strobe
//   oRespProd   : product, held between strobes
//   oBusy       : any pipeline stage valid
// Optional FPMUL_ARB_PERF_EN adds iCntClr and oGrantCnt (16-bit wrapping
// accept counter per requester, clear beats increment).
// Operands presented in the cycle after edge t are captured into stage 1 at
// edge t+1 and appear on the outputs after edge t+LAT.
module fp_mul_arbiter
    import fpmul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LAT     = 2
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic [NUM_REQ-1:0]      iReqValid,
    input  logic [NUM_REQ*FP_W-1:0] iReqA,
    input  logic [NUM_REQ*FP_W-1:0] iReqB,
    output logic [NUM_REQ-1:0]      oReqReady,
    output logic [NUM_REQ-1:0]      oRespValid,
    output logic [FP_W-1:0]         oRespProd,
    output logic                    oBusy
`ifdef FPMUL_ARB_PERF_EN
    ,
    input  logic                    iCntClr,
    output logic [NUM_REQ*16-1:0]   oGrantCnt
`endif
);

    logic [NUM_REQ-1:0] gnt;
    logic               accept;
    logic [FP_W-1:0]    sel_a;
    logic [FP_W-1:0]    sel_b;
    logic [FP_W-1:0]    core_prod;

    logic [LAT-1:0]     vld_q;
    logic [LAT-1:0]     vld_d;
    logic [NUM_REQ-1:0] tag_q [LAT];
    logic [NUM_REQ-1:0] tag_d [LAT];
    logic [FP_W-1:0]    dat_q [LAT];
    logic [FP_W-1:0]    dat_d [LAT];

    // grant only ever goes to a valid requester, so any grant is an accept
    assign accept = |gnt;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk_i     (iClk),
        .rst_i     (iRst),
        .req_i     (iReqValid),
        .advance_i (accept),
        .gnt_o     (gnt)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                sel_a = iReqA[k*FP_W +: FP_W];
                sel_b = iReqB[k*FP_W +: FP_W];
            end
        end
    end

    fpmul_core u_core (
        .a_i    (sel_a),
        .b_i    (sel_b),
        .prod_o (core_prod)
    );

    // data registers only load behind a valid entry, so the last stage
    // holds the previous product while no strobe is pending
    always_comb begin
        vld_d[0] = accept;
        tag_d[0] = gnt;
        dat_d[0] = accept ? core_prod : dat_q[0];
        for (int s = 1; s < LAT; s++) begin
            vld_d[s] = vld_q[s-1];
            tag_d[s] = tag_q[s-1];
            dat_d[s] = vld_q[s-1] ? dat_q[s-1] : dat_q[s];
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            vld_q <= '0;
            for (int s = 0; s < LAT; s++) begin
                tag_q[s] <= '0;
                dat_q[s] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            tag_q <= tag_d;
            dat_q <= dat_d;
        end
    end

    assign oReqReady  = gnt;
    assign oRespValid = vld_q[LAT-1] ? tag_q[LAT-1] : '0;
    assign oRespProd  = dat_q[LAT-1];
    assign oBusy      = |vld_q;

`ifdef FPMUL_ARB_PERF_EN
    logic [15:0] cnt_q [NUM_REQ];
    logic [15:0] cnt_d [NUM_REQ];

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            cnt_d[k] = iCntClr ? 16'd0 : cnt_q[k] + {15'd0, gnt[k]};
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            oGrantCnt[k*16 +: 16] = cnt_q[k];
        end
    end
`endif

endmodule
